// File: rtl/mem_pkg.sv
// Shared definitions for mem_master and its benches: default memory geometry,
// burst FSM states and the write/check data pattern.
package mem_pkg;

    localparam int MEM_WIDTH = 16;
    localparam int MEM_DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Word k of a burst is seed + k; callers truncate to their data width.
    function automatic logic [63:0] mem_pattern(input logic [63:0] seed, input logic [63:0] idx);
        return seed + idx;
    endfunction

endpackage

// File: rtl/mem_addr_gen.sv
// Burst address generator: loads a start address, then steps by one per
// transfer, wrapping naturally at DEPTH because DEPTH is a power of two.
module mem_addr_gen #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_addr;
        end else if (i_inc) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/mem_master.sv
// Burst initiator for the valid/ready memory: one command becomes len
// single-word transfers. Define MEM_MASTER_CHECK_EN to build read-data checking.
module mem_master
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ADDR_WIDTH:0]   cmd_len_i,
    input  logic [WIDTH-1:0]      cmd_seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  valid_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  rvalid_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o
);

    localparam int LEN_W = ADDR_WIDTH + 1;

    state_e             r_state;
    state_e             w_state_next;
    logic               r_valid;
    logic               r_wr_rd;
    logic [WIDTH-1:0]   r_wdata;
    logic [WIDTH-1:0]   r_seed;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_rvalid;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_k;

    logic               w_accept;
    logic               w_xfer;
    logic               w_last;
    logic [LEN_W-1:0]   w_len_clamped;
    logic [LEN_W-1:0]   w_k_inc;
    logic [WIDTH-1:0]   w_next_word;

    assign w_accept      = cmd_valid_i && (r_state == IDLE);
    assign w_len_clamped = (cmd_len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cmd_len_i;
    assign w_xfer        = r_valid && ready_i;
    assign w_last        = (r_k == r_len - LEN_W'(1));
    assign w_k_inc       = r_k + LEN_W'(1);
    assign w_next_word   = WIDTH'(mem_pattern(64'(r_seed), 64'(w_k_inc)));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_len_clamped == '0) ? DONE : XFER;
                end
            end
            XFER: begin
                if (w_xfer && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Request fields only move on accept or on a completed transfer, so the
    // slave always sees a stable request while it stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_valid  <= 1'b0;
            r_wr_rd  <= 1'b0;
            r_wdata  <= '0;
            r_seed   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_len    <= '0;
            r_k      <= '0;
        end else begin
            r_rvalid <= 1'b0;
            if (w_accept) begin
                r_len   <= w_len_clamped;
                r_seed  <= cmd_seed_i;
                r_wr_rd <= cmd_wr_rd_i;
                r_k     <= '0;
                r_wdata <= cmd_seed_i;
                r_valid <= (w_len_clamped != '0);
            end else if (w_xfer) begin
                if (!r_wr_rd) begin
                    r_rdata  <= rdata_i;
                    r_rvalid <= 1'b1;
                end
                if (w_last) begin
                    r_valid <= 1'b0;
                end else begin
                    r_k     <= w_k_inc;
                    r_wdata <= w_next_word;
                end
            end
        end
    end

    mem_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .i_clk       (clk_i),
        .i_rst_n     (rst_i),
        .i_load      (w_accept),
        .i_load_addr (cmd_addr_i),
        .i_inc       (w_xfer && !w_last),
        .o_addr      (addr_o)
    );

`ifdef MEM_MASTER_CHECK_EN
    logic [LEN_W-1:0] r_err_cnt;
    logic [WIDTH-1:0] w_expect;

    assign w_expect = WIDTH'(mem_pattern(64'(r_seed), 64'(r_k)));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_err_cnt <= '0;
        end else if (w_accept) begin
            r_err_cnt <= '0;
        end else if (w_xfer && !r_wr_rd && (rdata_i != w_expect) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + LEN_W'(1);
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = '0;
`endif

    assign cmd_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);
    assign valid_o     = r_valid;
    assign wr_rd_o     = r_wr_rd;
    assign wdata_o     = r_wdata;
    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: a bench-side memory slave with selectable
// ready behaviour, expected transfers queued at command issue.
module tb_mem_master;
    import mem_pkg::*;

    localparam int W  = MEM_WIDTH;
    localparam int D  = MEM_DEPTH;
    localparam int AW = $clog2(D);
    localparam int LW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_wr_rd_i;
    logic [AW-1:0] cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic [W-1:0]  cmd_seed_i;
    logic          busy_o;
    logic          done_o;
    logic          valid_o;
    logic          wr_rd_o;
    logic [AW-1:0] addr_o;
    logic [W-1:0]  wdata_o;
    logic          ready_i;
    logic [W-1:0]  rdata_i;
    logic          rvalid_o;
    logic [W-1:0]  rdata_o;
    logic [LW-1:0] err_cnt_o;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } xfer_t;

    xfer_t        exp_q[$];
    logic [W-1:0] rd_q[$];
    logic [W-1:0] mem[D];
    logic [W-1:0] ref_mem[D];

    int total = 0;
    int bad = 0;
    int rmode = 0;
    int wait_cnt = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    int exp_err = 0;
    int exp_n = 0;

    initial forever #5 clk = ~clk;

    mem_master #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_wr_rd_i (cmd_wr_rd_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_seed_i  (cmd_seed_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .valid_o     (valid_o),
        .wr_rd_o     (wr_rd_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .ready_i     (ready_i),
        .rdata_i     (rdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_cnt_o   (err_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory slave + monitor. ready_i modes: 0 always, 1 one cycle after
    // valid_o, 2 never, 3 only for the first two words of a burst.
    initial begin : slave
        xfer_t        e;
        logic [W-1:0] d;
        forever begin
            @(negedge clk);
            if (done_o) done_cnt++;
            if (valid_o) valid_cnt++;
            if (rvalid_o) begin
                if (rd_q.size() == 0) begin
                    chk("rvalid_extra", 32'(rvalid_o), 32'd0);
                end else begin
                    d = rd_q.pop_front();
                    chk("rdata", 32'(rdata_o), 32'(d));
                end
            end
            case (rmode)
                0:       ready_i = 1'b1;
                1:       ready_i = valid_o && (wait_cnt >= 1);
                2:       ready_i = 1'b0;
                default: ready_i = valid_o && (xfer_cnt < 2);
            endcase
            rdata_i = mem[addr_o];
            if (valid_o && ready_i) begin
                xfer_cnt++;
                wait_cnt = 0;
                if (exp_q.size() == 0) begin
                    chk("xfer_extra", 32'(valid_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_rd", 32'(wr_rd_o), 32'(e.wr));
                    chk("addr", 32'(addr_o), 32'(e.addr));
                    if (e.wr) begin
                        chk("wdata", 32'(wdata_o), 32'(e.data));
                        mem[addr_o] = wdata_o;
                        ref_mem[e.addr] = e.data;
                    end else begin
                        rd_q.push_back(e.data);
                    end
                end
            end else if (valid_o) begin
                wait_cnt++;
            end
        end
    end

    task automatic issue(input logic wr, input int addr, input int len, input logic [W-1:0] seed, input int mode);
        exp_n   = (len > D) ? D : len;
        exp_err = 0;
        for (int i = 0; i < exp_n; i++) begin
            xfer_t e;
            e.wr   = wr;
            e.addr = AW'((addr + i) % D);
            e.data = wr ? (seed + W'(i)) : ref_mem[(addr + i) % D];
`ifdef MEM_MASTER_CHECK_EN
            if (!wr && (e.data !== seed + W'(i)) && exp_err < (2 ** LW - 1)) exp_err++;
`endif
            exp_q.push_back(e);
        end
        @(negedge clk); #1;
        $display("cmd wr=%0d addr=%0d len=%0d seed=0x%04h ready_mode=%0d", wr, addr, len, seed, mode);
        rmode = mode; xfer_cnt = 0; done_cnt = 0; valid_cnt = 0; wait_cnt = 0;
        chk("cmd_ready", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_wr_rd_i = wr;
        cmd_addr_i  = AW'(addr);
        cmd_len_i   = LW'(len);
        cmd_seed_i  = seed;
        @(negedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int len, input int mode);
        int lat;
        bit got;
        lat = 1;
        got = done_o;
        while (!got && lat < 1000) begin
            @(negedge clk); #1;
            lat++;
            got = done_o;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_in_done", 32'(busy_o), 32'd1);
        chk("err_cnt", 32'(err_cnt_o), 32'(exp_err));
        if (mode == 0) chk("latency", 32'(lat), 32'(exp_n + 1));
        @(negedge clk); #1;
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("idle_ready", 32'(cmd_ready_o), 32'd1);
        chk("queues_empty", 32'(exp_q.size() + rd_q.size()), 32'd0);
        if (mode == 0) chk("valid_cycles", 32'(valid_cnt), 32'(exp_n));
        $display("burst end len=%0d err_cnt=%0d", len, err_cnt_o);
    endtask

    initial begin : main
        int guard;
        for (int i = 0; i < D; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_wr_rd_i = 1'b0;
        cmd_addr_i = '0; cmd_len_i = '0; cmd_seed_i = '0;
        ready_i = 1'b0; rdata_i = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_wr_rd", 32'(wr_rd_o), 32'd0);
        chk("rst_addr", 32'(addr_o), 32'd0);
        chk("rst_wdata", 32'(wdata_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", 32'(rdata_o), 32'd0);
        chk("rst_err", 32'(err_cnt_o), 32'd0);

        issue(1'b1, 0, 1, 16'h1000, 1);
        wait_done(1, 1);
        chk("mem0", 32'(mem[0]), 32'h1000);

        issue(1'b1, 60, 8, 16'hA5A0, 0);
        wait_done(8, 0);
        issue(1'b0, 60, 8, 16'hA5A0, 0);
        wait_done(8, 0);
        issue(1'b0, 60, 8, 16'hA5A1, 0);
        wait_done(8, 0);

        issue(1'b1, 5, 0, 16'h5555, 0);
        wait_done(0, 0);

        issue(1'b1, 15, 64, 16'h0100, 0);
        wait_done(64, 0);
        issue(1'b0, 15, 70, 16'h0100, 1);
        wait_done(70, 1);

        // Reset while the third word of a five-word write is stalled.
        issue(1'b1, 10, 5, 16'h3C00, 3);
        guard = 0;
        while (xfer_cnt < 2 && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("rst_test_two_xfers", 32'(xfer_cnt), 32'd2);
        @(negedge clk); #1;
        chk("stall_valid", 32'(valid_o), 32'd1);
        chk("stall_addr", 32'(addr_o), 32'd12);
        rst_i = 1'b0;
        @(negedge clk); #1;
        rst_i = 1'b1;
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 32'd0);

        issue(1'b1, 20, 3, 16'h7770, 1);
        wait_done(3, 1);
        issue(1'b0, 10, 12, 16'h3C00, 0);
        wait_done(12, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Hardware initiator for the single-port valid/ready memory (`memory`). It turns one command (direction, start address, length, data seed) into a burst of single-word memory transactions.
- On writes it generates a deterministic data pattern. On reads it streams the returned data out and, optionally, checks it against the same pattern.
- Sits between control logic (or a bench) and the memory slave port, replacing hand-driven per-word stimulus.

Parameters:
- WIDTH, 16, data word width; must match the memory.
- DEPTH, 64, number of memory locations; power of two.
- ADDR_WIDTH, $clog2(DEPTH), memory address width.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  reset: one clock; reset is synchronous and active-low.
- cmd_valid_i  input  1  command request.
- cmd_ready_o  output  1  high in IDLE only; a command is accepted on a rising edge with cmd_valid_i && cmd_ready_o.
- cmd_wr_rd_i  input  1  1 = write burst, 0 = read burst.
- cmd_addr_i  input  ADDR_WIDTH  burst start address.
- cmd_len_i  input  ADDR_WIDTH+1  number of words, 0..DEPTH.
- cmd_seed_i  input  WIDTH  pattern seed.
- busy_o  output  1  high while a burst is in progress.
- done_o  output  1  one-cycle pulse when a burst finishes.
- valid_o  output  1  memory request valid.
- wr_rd_o  output  1  memory direction.
- addr_o  output  ADDR_WIDTH  memory address.
- wdata_o  output  WIDTH  memory write data.
- ready_i  input  1  memory accept/complete.
- rdata_i  input  WIDTH  memory read data, valid in the cycle ready_i is high on a read.
- rvalid_o  output  1  one-cycle pulse: rdata_o is valid.
- rdata_o  output  WIDTH  captured read word.
- err_cnt_o  output  ADDR_WIDTH+1  read mismatches in the last burst (see Optional Feature).

Behaviour:
- Reset (rst_i == 0 at a rising edge): state goes to IDLE.
  - Reset values: cmd_ready_o=1 (as IDLE), busy_o=0, done_o=0, valid_o=0, wr_rd_o=0, addr_o=0, wdata_o=0, rvalid_o=0, rdata_o=0, err_cnt_o=0.
  - Reset mid-burst abandons the burst: valid_o drops at that edge and no done_o pulse is produced.
- States: IDLE, XFER, DONE.
- IDLE -> XFER on command accept with cmd_len_i != 0.
  - At that edge, latch direction, length and seed; set addr_o = cmd_addr_i, wdata_o = cmd_seed_i, valid_o = 1, wr_rd_o = cmd_wr_rd_i, err_cnt_o = 0, word index k = 0.
- IDLE -> DONE on command accept with cmd_len_i == 0. No memory transaction is issued; err_cnt_o is cleared.
- XFER, word transfer: a word transfers on a rising edge with valid_o && ready_i.
  - valid_o, addr_o, wr_rd_o and wdata_o are held stable until that edge (no retraction).
- XFER, after each transfer:
  - If k == len-1: go to DONE and set valid_o = 0.
  - Otherwise: k += 1, addr_o = (addr_o + 1) mod DEPTH (wraps DEPTH-1 -> 0), wdata_o = seed + k mod 2^WIDTH, and valid_o stays 1. Back-to-back transfers are therefore possible every cycle.
- Write data pattern: word k = cmd_seed_i + k, truncated to WIDTH bits.
- Read transfer: rdata_o <= rdata_i and rvalid_o pulses high for the next cycle. Exactly len pulses are produced per read burst.
- DONE: done_o = 1 for exactly one cycle, then return to IDLE. cmd_ready_o = 0 in DONE, so a new command is accepted no earlier than the cycle after done_o.
- busy_o = 1 in XFER and DONE.
- cmd_len_i values above DEPTH are clamped to DEPTH.
- ready_i is ignored while valid_o == 0.
- Minimum burst latency: accept edge, N transfer edges, then the done_o cycle.

Optional Feature:
- Macro: MEM_MASTER_CHECK_EN.
- When defined:
  - On each read transfer, compare rdata_i with seed + k (WIDTH bits).
  - On a mismatch, err_cnt_o increments, saturating at all-ones.
- When undefined: no compare logic is built and err_cnt_o is tied to 0.

Decomposition:
- Package mem_pkg holds:
  - the state enum (IDLE, XFER, DONE);
  - default WIDTH/DEPTH constants shared with `memory` and benches;
  - a pattern function (seed, index) -> word, used by both RTL and bench.
- One sub-module is natural: mem_addr_gen, which loads the start address, increments on transfer and wraps modulo DEPTH.

Test Plan:
- Write burst, seed 0x1000, addr 0, len 1, ready_i one cycle after valid_o -> one transfer with addr 0 and data 0x1000; done_o pulses once; the memory holds 0x1000 at location 0.
- Write burst, seed 0xA5A0, addr 60, len 8, ready_i tied 1 -> addresses 60, 61, 62, 63, 0, 1, 2, 3 (wrap); data 0xA5A0..0xA5A7; transfers occur every cycle; done_o pulses after the 8th.
- Read burst of the same region, same seed -> 8 rvalid_o pulses carrying 0xA5A0..0xA5A7; with MEM_MASTER_CHECK_EN, err_cnt_o = 0.
- Read burst with seed 0xA5A1 (wrong seed) -> with MEM_MASTER_CHECK_EN, err_cnt_o = 8; without it, err_cnt_o = 0.
- Burst of len 0 -> no valid_o assertion; done_o pulses one cycle after accept. A burst of len 64 from addr 15 covers all locations once.
- rst_i driven low during the 3rd word of a 5-word write with ready_i stalled -> valid_o = 0 and cmd_ready_o = 1 after that edge; no done_o pulse; the next command runs normally.
